cdc_hs_src: RTL
===============

CDC_HS_SRC -- requirements
Module: cdc_hs_src

Interface
- REQ-001: Parameters SHALL be:
  - DATA_WIDTH, default 16: payload width.
  - SYNC_WIDTH, default 2: ack synchronizer depth.
  - TIMEOUT_CYCLES, default 64: wait-state limit in cycles; 0 disables the timeout.
- REQ-002: clk_i, input, 1: single clock; the block is fully synchronous to it.
- REQ-003: rst_i, input, 1: reset, synchronous and active-high.
- REQ-004: valid_i, input, 1: source requests a transfer.
- REQ-005: data_i, input, DATA_WIDTH: payload, captured on accept.
- REQ-006: ready_o, output, 1: block can accept a transfer; high only in IDLE.
- REQ-007: req_o, output, 1: registered 4-phase request to the destination domain.
- REQ-008: data_o, output, DATA_WIDTH: registered payload to the destination domain.
- REQ-009: ack_i, input, 1: asynchronous acknowledge from the destination domain.
- REQ-010: done_o, output, 1: one-cycle pulse when a handshake completes.
- REQ-011: timeout_o, output, 1: sticky timeout error flag.
- REQ-012: clr_i, input, 1: clears timeout_o.

Function
- REQ-013: ack_i SHALL pass through a SYNC_WIDTH-stage synchronizer to give ack_s; the FSM SHALL use only ack_s.
- REQ-014: The FSM SHALL have states IDLE, REQ_HI and REQ_LO.
- REQ-015: In IDLE with valid_i=1, ready_o=1 and ack_s=0 at edge N:
  - data_o SHALL capture data_i at edge N.
  - req_o SHALL be 1 from cycle N+1.
  - The FSM SHALL move to REQ_HI.
- REQ-016: In IDLE with ack_s=1, ready_o SHALL be 0 and no transfer SHALL be accepted.
- REQ-017: In REQ_HI, on the first edge with ack_s=1, req_o SHALL go to 0 on the next cycle and the FSM SHALL move to REQ_LO.
- REQ-018: In REQ_LO, on the first edge with ack_s=0:
  - done_o SHALL be 1 for exactly the next cycle.
  - The FSM SHALL move to IDLE, with ready_o=1 in that same cycle.
- REQ-019: data_o SHALL stay stable from accept until the next accept; valid_i and data_i SHALL be ignored while ready_o=0.
- REQ-020: Minimum handshake latency from accept to done_o SHALL be 2*SYNC_WIDTH+2 cycles when ack_i follows req_o with zero delay.
- REQ-021: The wait counter SHALL be width $clog2(TIMEOUT_CYCLES+1), SHALL clear on entry to REQ_HI and REQ_LO, and SHALL increment each cycle in those states.
- REQ-022: When the wait counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES>0):
  - timeout_o SHALL set to 1.
  - req_o SHALL go to 0.
  - The FSM SHALL move to IDLE.
  - done_o SHALL NOT pulse.
  - The next accept remains gated by ack_s=0.
- REQ-023: clr_i=1 SHALL clear timeout_o on the next edge; if a timeout occurs in the same cycle as clr_i, the set SHALL win.
- REQ-024: The wait counter SHALL saturate and never wrap.

Reset
- REQ-025: rst_i=1 at any edge, including mid-handshake, SHALL force the following on the next cycle:
  - FSM to IDLE.
  - req_o=0, data_o=0, done_o=0, timeout_o=0.
  - Wait counter to 0.
  - All synchronizer stages to 0.
- REQ-026: After rst_i deasserts, ready_o SHALL be 1 in the first cycle in which ack_s=0.

Structure
- REQ-027: The state enum typedef and default parameter constants SHALL live in the shared package cdc_pkg.
- REQ-028: The ack synchronizer SHALL be one sync_ff instance:
  - SYNC_WIDTH=SYNC_WIDTH, RESET_VAL=0.
  - rst_ni driven from registered ~rst_i.
- REQ-029: No other sub-module SHALL be used.

Verification
- REQ-030: With SYNC_WIDTH=2 and TIMEOUT_CYCLES=64, the bench SHALL use a responder that mirrors req_o into ack_i after a 3-cycle delay.
- REQ-031: Single transfer. Stimulus: accept 16'hA5C3. Response: data_o=16'hA5C3 throughout the handshake, req_o high then low, exactly one done_o pulse, ready_o back to 1.
- REQ-032: Back-to-back. Stimulus: valid_i held high for 16 transfers with data 0..15. Response: 16 done_o pulses, data_o in order, req_o never rising while ack_s=1.
- REQ-033: Missing ack. Stimulus: responder disabled. Response: 64 cycles after entering REQ_HI, timeout_o=1, req_o=0, FSM in IDLE, no done_o; clr_i=1 then gives timeout_o=0.
- REQ-034: Reset mid-handshake. Stimulus: rst_i=1 for 1 cycle while in REQ_HI. Response: next cycle req_o=0, done_o=0, timeout_o=0, data_o=0, ready_o=1 once ack_s=0.
- REQ-035: Busy input. Stimulus: data_i set to 16'hFFFF with valid_i=1 during REQ_LO. Response: data_o unchanged and no extra transfer.
- REQ-036: Clear/timeout collision. Stimulus: clr_i=1 in the exact cycle the timeout fires. Response: timeout_o=1 afterwards.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the clock-domain-crossing handshake source.
// The source FSM and the bench both refer to these.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } hs_state_e;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_SYNC_WIDTH     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Wait-counter width; a disabled timeout still needs a legal 1-bit vector.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage single-bit synchronizer with an asynchronous active-low clear.
// The output is the last stage.
module sync_ff #(
  parameter int   SYNC_WIDTH = 2,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_WIDTH-1:0] stage;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage <= {SYNC_WIDTH{RESET_VAL}};
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < SYNC_WIDTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q_o = stage[SYNC_WIDTH-1];

endmodule

// File: rtl/cdc_hs_src.sv
// Source side of a 4-phase req/ack handshake: captures one payload per
// transfer, holds it stable, and waits on the synchronized acknowledge.
module cdc_hs_src
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SYNC_WIDTH     = DEF_SYNC_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  timeout_o,
  input  logic                  clr_i
);

  localparam int            CW        = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

  logic sync_rst_n;
  logic ack_s;

  // Registered reset keeps the synchronizer clear decoupled from rst_i timing.
  always_ff @(posedge clk_i) sync_rst_n <= ~rst_i;

  sync_ff #(
    .SYNC_WIDTH(SYNC_WIDTH),
    .RESET_VAL (1'b0)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_ni(sync_rst_n),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  hs_state_e     state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt, wait_inc;
  logic          req_nxt, done_nxt, capture, to_hit, to_fire;

  assign ready_o  = (state == IDLE) && !ack_s;
  assign wait_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
  assign to_hit   = (TIMEOUT_CYCLES > 0) && (wait_inc == CNT_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // A real acknowledge edge takes priority over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_o;
    wait_nxt  = wait_cnt;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    to_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_i && ready_o) begin
          capture   = 1'b1;
          req_nxt   = 1'b1;
          wait_nxt  = '0;
          state_nxt = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          wait_nxt  = '0;
          state_nxt = REQ_LO;
        end else begin
          wait_nxt = wait_inc;
          to_fire  = to_hit;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_inc;
          to_fire  = to_hit;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (to_fire) begin
      req_nxt   = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_o     <= 1'b0;
      data_o    <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      req_o    <= req_nxt;
      done_o   <= done_nxt;
      wait_cnt <= wait_nxt;
      if (capture) data_o <= data_i;
      // Set beats clear when both land on the same edge.
      if (to_fire)    timeout_o <= 1'b1;
      else if (clr_i) timeout_o <= 1'b0;
    end
  end

endmodule
